// File: rtl/ascii_char_sequencer_pkg.sv
// Shared constants and state encoding for the ASCII character sequencer.
// The bus carries N_CHARS packed 7-bit characters plus one unused pad bit.
package ascii_char_sequencer_pkg;

    localparam int N_CHARS = 146;
    localparam int CHAR_W  = 7;
    localparam int BUS_W   = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ascii_char_sequencer_slot_mux.sv
// Selects one CHAR_W-bit character slot from the latched shadow register.
// Out-of-range indices return NUL.
module ascii_slot_mux #(
    parameter int N_CHARS = 146,
    parameter int CHAR_W  = 7
) (
    input  logic [N_CHARS*CHAR_W-1:0] shadow_i,
    input  logic [7:0]                idx_i,
    output logic [CHAR_W-1:0]         char_o
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves char_o unassigned (no latch).
        char_o = '0;
        if (int'(idx_i) < N_CHARS) begin
            char_o = shadow_i[int'(idx_i)*CHAR_W +: CHAR_W];
        end
    end

endmodule

// File: rtl/ascii_char_sequencer.sv
// Latches a packed ASCII message on start and streams it out one character per
// valid/ready handshake, optionally stopping after a NUL character.
module ascii_char_sequencer
    import ascii_char_sequencer_pkg::*;
#(
    parameter int N_CHARS     = ascii_char_sequencer_pkg::N_CHARS,
    parameter int CHAR_W      = ascii_char_sequencer_pkg::CHAR_W,
    parameter bit STOP_ON_NUL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BUS_W-1:0]  ascii_IN,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              abort,
    input  logic              char_ready,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    output logic [7:0]        char_idx,
    output logic              busy,
    output logic              done
);

    localparam int         SHADOW_W  = N_CHARS * CHAR_W;
    localparam logic [7:0] MAX_COUNT = 8'(N_CHARS);

    state_e              state_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [7:0]          count_q;
    logic [7:0]          count_d;
    logic [7:0]          idx_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                last_char;
    logic                unused_pad;

    assign unused_pad = ^ascii_IN[BUS_W-1:SHADOW_W];

    assign count_d   = (len > MAX_COUNT) ? MAX_COUNT : len;
    assign last_char = (idx_q == count_q - 8'd1) ||
                       (STOP_ON_NUL && (char_out == '0));

    ascii_slot_mux #(
        .N_CHARS (N_CHARS),
        .CHAR_W  (CHAR_W)
    ) u_slot_mux (
        .shadow_i (shadow_q),
        .idx_i    (idx_q),
        .char_o   (char_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide shadow register is reset too, so char_out reads 0 while in reset.
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shadow_q <= ascii_IN[SHADOW_W-1:0];
                        count_q  <= count_d;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        if (count_d == 8'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SEND;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // Abort wins over a handshake landing in the same cycle.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (char_ready) begin
                        if (last_char) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign char_valid = valid_q;
    assign char_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/ascii_char_sequencer.md
ASCII_CHAR_SEQUENCER -- requirements
Module: ascii_char_sequencer

Interface
REQ-001 Parameter N_CHARS, default 146: number of character slots in the packed input bus.
REQ-002 Parameter CHAR_W, default 7: bits per ASCII character.
REQ-003 Parameter STOP_ON_NUL, default 1: when 1, a 7'h00 character ends the sequence early.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ascii_IN  input  1023  packed characters; slot k occupies bits [7k+6:7k]; bit 1022 unused.
REQ-007 start  input  1  request to send one message; sampled only in IDLE.
REQ-008 len  input  8  number of characters to send; sampled with start.
REQ-009 abort  input  1  cancels an active transfer.
REQ-010 char_ready  input  1  downstream accepts char_out this cycle.
REQ-011 char_out  output  7  current character.
REQ-012 char_valid  output  1  char_out is valid.
REQ-013 char_idx  output  8  slot index of char_out.
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 done  output  1  one-cycle pulse at normal completion.

Function
REQ-016 States SHALL be IDLE, SEND, DONE; encoding is free.
REQ-017 In IDLE with start=1: latch ascii_IN into a 1022-bit shadow register; latch count = min(len, N_CHARS); clear index to 0; go to SEND if count>0, else go to DONE.
REQ-018 Input changes to ascii_IN, len or start after the latch SHALL NOT affect the transfer in progress.
REQ-019 char_valid SHALL be 1 exactly while in SEND; first valid character appears the cycle after start was sampled (latency 1).
REQ-020 char_out SHALL equal shadow slot char_idx and SHALL hold stable, with char_idx, until char_valid&&char_ready.
REQ-021 On char_valid&&char_ready: if char_idx==count-1, or STOP_ON_NUL=1 and char_out==7'h00, go to DONE; otherwise increment char_idx.
REQ-022 A NUL character SHALL itself be presented and handshaken before termination.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start sampled in DONE SHALL be ignored.
REQ-024 start while busy SHALL be ignored, with no effect on shadow, count or index.
REQ-025 abort=1 in SEND or DONE SHALL return to IDLE next cycle with done=0; abort has priority over a simultaneous handshake; abort in IDLE has no effect and does not block start.
REQ-026 char_idx SHALL never exceed N_CHARS-1; count and index arithmetic is 8-bit unsigned with no wrap.
REQ-027 Outputs in IDLE: char_valid=0, busy=0, done=0, char_out=shadow slot 0, char_idx=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, shadow=0, count=0, char_idx=0, char_out=0, char_valid=0, busy=0, done=0, including mid-transfer.
REQ-029 The first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold N_CHARS, CHAR_W, the packed bus width (1023) and the state enumeration.
REQ-031 Slot extraction (shadow, index -> 7-bit character) SHALL be a sub-module ascii_slot_mux; the control FSM and counters stay in the top module.

Verification
REQ-032 Start with len=3, slots "A","B","C" (7'h41,7'h42,7'h43), char_ready=1 -> valid for 3 consecutive cycles, idx 0,1,2; done pulse on the 4th cycle.
REQ-033 Same message with char_ready toggling 1,0,1,0,… -> char_out and char_idx held through every stall; 3 handshakes total; done once.
REQ-034 len=10, slot 4=7'h00, STOP_ON_NUL=1 -> 5 handshakes (idx 0..4, last char 7'h00), then done.
REQ-035 len=0 -> no char_valid; done pulses at start+1; len=200 -> exactly 146 handshakes, final idx 145.
REQ-036 abort asserted at idx 2 together with char_ready=1 -> IDLE next cycle, done never pulses; a new start is then accepted normally.
REQ-037 rst_n pulsed low mid-transfer at idx 5 -> all outputs 0 immediately; start ignored while busy confirmed by holding start=1 throughout a len=4 transfer.
